digit_match_sequencer: RTL and testbench
========================================

# digit_match_sequencer

Sequential classifier for the 11×11, 8-bit digit image produced by the digit-capture path. The block uses one time-shared absolute-difference datapath to compare the image against ten stored digit templates (0–9), one pixel per cycle. For each template it accumulates a distance score and keeps the running minimum. It reports the best-matching digit and its score to the game logic through a start/busy/done handshake.

## Interface
- N_DIGITS, 10, number of templates compared
- SIDE, 11, image edge length; pixel count NPIX = SIDE*SIDE = 121
- PIX_W, 8, pixel width
- SCORE_W, 16, score width (≥ ceil(log2(NPIX*255+1)) = 15)

- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a classification; sampled only in IDLE
- img_addr  out  7  pixel index into the external image buffer, row-major (row*SIDE+col)
- img_data  in  PIX_W  buffer read data; valid one cycle after img_addr
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when result is valid
- digit  out  4  index of the best-matching template; held until the next done
- best_score  out  SCORE_W  distance of the best template; held until the next done

## Operation
- FSM states: IDLE, FETCH, FLUSH, COMPARE, DONE.
- IDLE:
  - start=1 → FETCH.
  - Clear template counter t, pixel counter p and accumulator acc.
- FETCH:
  - img_addr = p and ROM address = t*NPIX+p, issued together.
  - p increments each cycle.
  - After p = NPIX-1, go to FLUSH.
- Datapath pipeline:
  - Stage 1: image/ROM data returns.
  - Stage 2: d = |img_data − tmpl| in PIX_W bits, registered.
  - acc += d, zero-extended to SCORE_W. acc never overflows by construction.
- FLUSH: 2 cycles to drain the pipeline. No new addresses are issued.
- COMPARE:
  - If t==0 or acc < best, load best := acc and best_idx := t.
  - Ties keep the lower index (strict less-than).
  - Clear acc and p.
  - If t == N_DIGITS-1 → DONE; otherwise t++ → FETCH.
- DONE:
  - digit := best_idx, best_score := best, done=1 for one cycle.
  - Next state is IDLE.
- start outside IDLE is ignored and is not queued.
- img_addr = 0 in every state except FETCH.

## Timing
- Reset values: busy=0, done=0, digit=0, best_score=0, img_addr=0, state=IDLE, all counters and accumulators 0.
- Cycle numbering: cycle 0 is the IDLE cycle in which start=1 is sampled.
- Template t occupies cycles 1+124t … 124+124t:
  - 121 FETCH cycles
  - 2 FLUSH cycles
  - 1 COMPARE cycle
- busy is high in cycles 1…1240.
- DONE is cycle 1241: done=1, busy=0, and digit/best_score update in the same cycle.
- The earliest next accepted start is cycle 1242.
- Latency scales as N_DIGITS*(NPIX+3)+1 cycles.
- Reset asserted mid-run:
  - Immediate abort to the reset values, including digit and best_score.
  - No done pulse is produced.
- The image buffer must stay stable from cycle 1 to cycle 1240; the block does not snapshot it.

## Structure
- Package digit_match_pkg holds:
  - N_DIGITS, SIDE, NPIX, PIX_W, SCORE_W
  - state enum
  - template constant array TEMPLATES[N_DIGITS][NPIX] of PIX_W, the canonical stored digit images
- Sub-module digit_template_rom:
  - Synchronous read, 1-cycle latency.
  - 11-bit address t*NPIX+p, initialised from TEMPLATES.
  - Maps to M4K on the DE2.
- Absolute difference, accumulator, counters and FSM stay in the top module.

## Test plan
- Reset: hold rst_n=0 → all outputs 0. Release and idle 20 cycles → busy=0, done never pulses.
- Exact match:
  - Image = TEMPLATES[7]; start pulse at cycle 0.
  - Expect busy in cycles 1–1240.
  - Expect done only at cycle 1241, with digit=7 and best_score=0.
  - Expect img_addr to sweep 0…120 ten times.
- Blank image: all pixels 0 → digit = argmin over t of sum(TEMPLATES[t]), and best_score equals that sum (reference model computed from the package).
- Tie: override two templates (3 and 5) with identical content equal to the image → digit=3, score 0.
- Saturation: all pixels 255 → best_score = min over t of sum(255−TEMPLATES[t]) ≤ 30855, with no wrap.
- Protocol:
  - start held high through the run: exactly one done at cycle 1241, and a new run is accepted at 1242.
  - rst_n pulsed low at cycle 500: outputs clear, no done pulse, and the next start completes normally.

Source files
------------

// File: rtl/digit_match_pkg.sv
// rtl/digit_match_pkg.sv - shared sizes, FSM encoding and stored digit templates
// Purpose: constants for the digit classifier plus the canonical template set.
// Ports: none (package).
package digit_match_pkg;

  localparam int N_DIGITS = 10;
  localparam int SIDE     = 11;
  localparam int NPIX     = SIDE * SIDE;
  localparam int PIX_W    = 8;
  localparam int SCORE_W  = 16;
  localparam int ROM_AW   = 11;
  localparam int IMG_AW   = 7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_FLUSH   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Template t, pixel p lives at bits (t*NPIX+p)*PIX_W of the flattened vector.
  typedef logic [N_DIGITS-1:0][NPIX-1:0][PIX_W-1:0] tmpl_t;

  // Seven-segment encoding {a,b,c,d,e,f,g} of each digit glyph.
  function automatic logic [6:0] digit_segs(input int d);
    logic [6:0] s;
    case (d)
      0:       s = 7'h7E;
      1:       s = 7'h30;
      2:       s = 7'h6D;
      3:       s = 7'h79;
      4:       s = 7'h33;
      5:       s = 7'h5B;
      6:       s = 7'h5F;
      7:       s = 7'h70;
      8:       s = 7'h7F;
      9:       s = 7'h7B;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Segment geometry on the 11x11 grid; no two segments share a pixel.
  function automatic logic seg_lit(input logic [6:0] s, input int r, input int c);
    logic on;
    on = 1'b0;
    if (s[6] && r == 1 && c >= 3 && c <= 7) on = 1'b1;
    if (s[5] && c == 8 && r >= 2 && r <= 4) on = 1'b1;
    if (s[4] && c == 8 && r >= 6 && r <= 8) on = 1'b1;
    if (s[3] && r == 9 && c >= 3 && c <= 7) on = 1'b1;
    if (s[2] && c == 2 && r >= 6 && r <= 8) on = 1'b1;
    if (s[1] && c == 2 && r >= 2 && r <= 4) on = 1'b1;
    if (s[0] && r == 5 && c >= 3 && c <= 7) on = 1'b1;
    return on;
  endfunction

  // Lit strokes read 220; background is a faint vertical ramp (10 + row).
  function automatic tmpl_t build_templates();
    tmpl_t tm;
    tm = '0;
    for (int t = 0; t < N_DIGITS; t++) begin
      for (int r = 0; r < SIDE; r++) begin
        for (int c = 0; c < SIDE; c++) begin
          tm[t][r*SIDE+c] = seg_lit(digit_segs(t), r, c) ? PIX_W'(220) : PIX_W'(10 + r);
        end
      end
    end
    return tm;
  endfunction

  localparam tmpl_t TEMPLATES = build_templates();

endpackage

// File: rtl/digit_match_sequencer_if.sv
// rtl/digit_match_sequencer_if.sv - classifier handshake and image-buffer bus
// Purpose: bundles start/busy/done, image read port and result outputs.
// Ports: master = game logic / image buffer side, slave = classifier side.
interface digit_match_sequencer_if;
  import digit_match_pkg::*;

  logic                start;
  logic [IMG_AW-1:0]   img_addr;
  logic [PIX_W-1:0]    img_data;
  logic                busy;
  logic                done;
  logic [3:0]          digit;
  logic [SCORE_W-1:0]  best_score;

  modport master (
    output start, img_data,
    input  img_addr, busy, done, digit, best_score
  );

  modport slave (
    input  start, img_data,
    output img_addr, busy, done, digit, best_score
  );

endinterface

// File: rtl/digit_template_rom.sv
// rtl/digit_template_rom.sv - synchronous template ROM, one-cycle read latency
// Purpose: holds all template pixels, addressed by t*NPIX+p.
// Ports: clk, addr (11-bit flat pixel address), data (registered pixel).
module digit_template_rom
  import digit_match_pkg::*;
#(
  parameter tmpl_t INIT = TEMPLATES
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [PIX_W-1:0]  data
);

  localparam logic [N_DIGITS*NPIX*PIX_W-1:0] FLAT = INIT;

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    data <= FLAT[addr*PIX_W +: PIX_W];
  end

endmodule

// File: rtl/digit_match_sequencer.sv
// rtl/digit_match_sequencer.sv - sequential nearest-template digit classifier
// Purpose: sums |image - template| per template, one pixel per cycle, and
//          reports the template with the smallest sum.
// Ports: clk, rst_n (async active-low), bus (slave modport: start, img_addr,
//        img_data, busy, done, digit, best_score).
module digit_match_sequencer
  import digit_match_pkg::*;
#(
  parameter tmpl_t TMPL = TEMPLATES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  digit_match_sequencer_if.slave  bus
);

  localparam logic [2:0] IDLE    = S_IDLE;
  localparam logic [2:0] FETCH   = S_FETCH;
  localparam logic [2:0] FLUSH   = S_FLUSH;
  localparam logic [2:0] COMPARE = S_COMPARE;
  localparam logic [2:0] DONE    = S_DONE;

  logic [2:0]         state;
  logic [3:0]         t;
  logic [IMG_AW-1:0]  p;
  logic               flush_cnt;
  logic [SCORE_W-1:0] acc;
  logic [SCORE_W-1:0] best;
  logic [3:0]         best_idx;
  logic [3:0]         digit_q;
  logic [SCORE_W-1:0] score_q;
  logic               v1;
  logic               v2;
  logic [PIX_W-1:0]   diff;
  logic [PIX_W-1:0]   tmpl_data;
  logic [ROM_AW-1:0]  rom_addr;
  logic               take;
  logic [SCORE_W-1:0] next_best;
  logic [3:0]         next_idx;

  assign rom_addr = ROM_AW'(t) * ROM_AW'(NPIX) + ROM_AW'(p);

  digit_template_rom #(
    .INIT (TMPL)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (tmpl_data)
  );

  // Strict less-than keeps the lower index on ties; template 0 always seeds.
  assign take      = (t == 4'd0) || (acc < best);
  assign next_best = take ? acc : best;
  assign next_idx  = take ? t : best_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      t         <= '0;
      p         <= '0;
      flush_cnt <= 1'b0;
      acc       <= '0;
      best      <= '0;
      best_idx  <= '0;
      digit_q   <= '0;
      score_q   <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      diff      <= '0;
    end else begin
      // v1 marks the cycle image/ROM data returns, v2 the cycle diff is valid.
      v1   <= (state == FETCH);
      v2   <= v1;
      diff <= (bus.img_data >= tmpl_data) ? (bus.img_data - tmpl_data)
                                          : (tmpl_data - bus.img_data);
      if (v2) acc <= acc + SCORE_W'(diff);

      case (state)
        IDLE: begin
          t   <= '0;
          p   <= '0;
          acc <= '0;
          if (bus.start) state <= FETCH;
        end
        FETCH: begin
          if (p == IMG_AW'(NPIX - 1)) begin
            p         <= '0;
            flush_cnt <= 1'b0;
            state     <= FLUSH;
          end else begin
            p <= p + 1'b1;
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= COMPARE;
        end
        COMPARE: begin
          best     <= next_best;
          best_idx <= next_idx;
          acc      <= '0;
          p        <= '0;
          if (t == 4'(N_DIGITS - 1)) begin
            // Load results here so they are visible alongside done.
            digit_q <= next_idx;
            score_q <= next_best;
            state   <= DONE;
          end else begin
            t     <= t + 1'b1;
            state <= FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.img_addr   = (state == FETCH) ? p : '0;
  assign bus.busy       = (state == FETCH) || (state == FLUSH) || (state == COMPARE);
  assign bus.done       = (state == DONE);
  assign bus.digit      = digit_q;
  assign bus.best_score = score_q;

endmodule

// File: tb/tb_digit_match_sequencer.sv
// tb/tb_digit_match_sequencer.sv - directed self-checking bench for digit_match_sequencer
module tb_digit_match_sequencer;
  import digit_match_pkg::*;

  function automatic tmpl_t make_tie();
    tmpl_t m;
    m    = TEMPLATES;
    m[5] = m[3];
    return m;
  endfunction

  localparam tmpl_t TIE_TMPL = make_tie();

  logic clk = 1'b0;
  logic rst_n;
  logic start_v;
  bit   sel;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [PIX_W-1:0] img_mem [128];

  always #5 clk = ~clk;

  digit_match_sequencer_if bus ();
  digit_match_sequencer_if bus2 ();

  digit_match_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  digit_match_sequencer #(
    .TMPL (TIE_TMPL)
  ) dut_tie (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus.start  = start_v & ~sel;
  assign bus2.start = start_v & sel;

  always @(posedge clk) begin
    bus.img_data  <= img_mem[bus.img_addr];
    bus2.img_data <= img_mem[bus2.img_addr];
  end

  logic               busy_m;
  logic               done_m;
  logic [6:0]         addr_m;
  logic [3:0]         digit_m;
  logic [SCORE_W-1:0] score_m;
  assign busy_m  = sel ? bus2.busy       : bus.busy;
  assign done_m  = sel ? bus2.done       : bus.done;
  assign addr_m  = sel ? bus2.img_addr   : bus.img_addr;
  assign digit_m = sel ? bus2.digit      : bus.digit;
  assign score_m = sel ? bus2.best_score : bus.best_score;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_tmpl(input int d);
    for (int i = 0; i < 128; i++) img_mem[i] = (i < NPIX) ? TEMPLATES[d][i] : 8'd0;
  endtask

  task automatic load_const(input logic [PIX_W-1:0] v);
    for (int i = 0; i < 128; i++) img_mem[i] = (i < NPIX) ? v : 8'd0;
  endtask

  // Starts a run at cycle 0 and checks busy/img_addr every cycle up to 1241.
  task automatic do_run(input bit hold, input logic [3:0] exp_digit,
                        input logic [SCORE_W-1:0] exp_score, input string tag);
    int busy_err = 0;
    int addr_err = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int loc;
    logic exp_busy;
    logic [6:0] exp_addr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_v = 1'b1;
    for (int k = 1; k <= 1241; k++) begin
      @(posedge clk);
      #1;
      if (!hold) start_v = 1'b0;
      exp_busy = (k <= 1240);
      if (busy_m !== exp_busy) busy_err++;
      loc = (k - 1) % 124;
      exp_addr = (k <= 1240 && loc < NPIX) ? 7'(loc) : 7'd0;
      if (addr_m !== exp_addr) addr_err++;
      if (done_m === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
    end
    check({tag, "_busy_err"}, busy_err, 0);
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, 1241);
    check({tag, "_digit"}, digit_m, exp_digit);
    check({tag, "_score"}, score_m, exp_score);
  endtask

  initial begin
    int dc;
    int bc;
    int c;
    rst_n   = 1'b0;
    start_v = 1'b0;
    sel     = 1'b0;
    load_const(8'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_digit", bus.digit, 0);
    check("rst_score", bus.best_score, 0);
    check("rst_addr", bus.img_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    bc = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) dc++;
      if (bus.busy !== 1'b0) bc++;
    end
    check("idle_busy_cnt", bc, 0);
    check("idle_done_cnt", dc, 0);

    // Exact match to template 7
    load_tmpl(7);
    do_run(1'b0, 4'd7, 16'd0, "exact7");

    // Blank image: digit 1 has the fewest lit pixels -> 1815 + 621 + 609
    load_const(8'd0);
    do_run(1'b0, 4'd1, 16'd3045, "blank");

    // All 255: digit 8 has the heaviest template (7350) -> 30855 - 7350
    load_const(8'd255);
    do_run(1'b0, 4'd8, 16'd23505, "sat");

    // Tie: templates 3 and 5 identical to the image, lower index wins
    sel = 1'b1;
    load_tmpl(3);
    do_run(1'b0, 4'd3, 16'd0, "tie");
    sel = 1'b0;

    // start held high: single done, next run accepted at cycle 1242
    load_tmpl(2);
    do_run(1'b1, 4'd2, 16'd0, "hold");
    @(posedge clk);
    #1;
    check("hold_1242_busy", bus.busy, 0);
    check("hold_1242_done", bus.done, 0);
    @(posedge clk);
    #1;
    check("hold_1243_busy", bus.busy, 1);
    start_v = 1'b0;
    c = 0;
    for (int i = 1; i <= 1300; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        c = i;
        break;
      end
    end
    check("hold_second_done_at", c, 1240);
    check("hold_second_digit", bus.digit, 2);

    // Reset at cycle 500 aborts the run
    load_tmpl(4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_v = 1'b1;
    dc = 0;
    for (int k = 1; k <= 500; k++) begin
      @(posedge clk);
      #1;
      start_v = 1'b0;
      if (bus.done === 1'b1) dc++;
    end
    check("mid_busy_before", bus.busy, 1);
    check("mid_digit_before", bus.digit, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_digit", bus.digit, 0);
    check("mid_rst_score", bus.best_score, 0);
    check("mid_rst_addr", bus.img_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dc++;
    end
    check("mid_no_done", dc, 0);
    do_run(1'b0, 4'd4, 16'd0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
